hazard_unit_pipe: RTL
=====================

Name: hazard_unit_pipe

Overview:
- Parametrised pipeline interlock unit for the RV32I 5-stage core; sits beside the IF/ID/EX/MEM pipeline registers and drives their enables and flushes.
- Functions:
  - load-use stalls across a configurable number of post-EX load stages, using per-instruction rs1/rs2 usage to avoid false stalls;
  - whole-pipeline freeze while data memory is not ready, with a timeout flag;
  - taken-branch/jump flush;
  - stall-cycle performance counter.

Parameters:
- NUM_LOAD_STAGES, 1, stages (EX counted as 1) during which a load result is not forwardable; 1..4.
- MEM_TIMEOUT, 255, maximum consecutive freeze cycles before mem_timeout asserts; ≥1.
- STALL_CNT_W, 32, stall counter width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- inst_ID_i  in  32  instruction in ID
- inst_EX_i  in  32  instruction in EX (bubble = 32'h00000013)
- br_taken_EX_i  in  1  taken branch/JAL/JALR resolved in EX
- mem_ready_i  in  1  data memory can complete this cycle
- pc_en  out  1  PC update enable
- IF_ID_en  out  1  IF/ID register enable
- IF_ID_flush  out  1  IF/ID loads bubble
- ID_EX_flush  out  1  ID/EX loads bubble
- pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB registers
- mem_timeout  out  1  sticky freeze-timeout error
- stall_cnt  out  STALL_CNT_W  cycles with pc_en=0

Behaviour:
- Decode uses opcode = inst[6:2] and rd = inst[11:7].
  - Load: opcode 00000.
  - rs1 used unless opcode is 01101, 00101 or 11011.
  - rs2 used only for opcodes 01100, 01000, 11000.
- Pending-load pipe: valid/rd shift register, depth NUM_LOAD_STAGES-1 (empty when the parameter is 1).
  - Entry 0 receives {isload_EX & rd_EX≠0, rd_EX}.
  - Shifts only when pipe_en=1 and rst_ni=1; otherwise holds.
- load_hz: an ID-used source (nonzero) equals rd of either a load in EX (rd≠0) or a valid pending entry j < NUM_LOAD_STAGES-1.
- Priority, all outputs combinational from inputs and state:
  - FREEZE: mem_ready_i=0 → pc_en=0, IF_ID_en=0, pipe_en=0, both flushes 0.
  - BRANCH: else if br_taken_EX_i → all enables 1, IF_ID_flush=1, ID_EX_flush=1; load_hz ignored.
  - LOAD STALL: else if load_hz → pc_en=0, IF_ID_en=0, pipe_en=1, ID_EX_flush=1.
  - RUN: else → all enables 1, flushes 0.
- FSM states RUN / WAIT, registered.
  - RUN→WAIT when mem_ready_i=0.
  - WAIT→RUN when mem_ready_i=1.
  - wait_cnt counts cycles in WAIT, saturates at MEM_TIMEOUT, and clears on the WAIT→RUN transition.
  - mem_timeout sets on the cycle wait_cnt reaches MEM_TIMEOUT and stays set until reset.
- Branch during a freeze: no flush while mem_ready_i=0. br_taken_EX_i is held by the frozen EX, so the flush applies on the first ready cycle.
- stall_cnt: +1 each cycle with pc_en=0 outside reset; saturates at all-ones.
- Reset (rst_ni=0, asynchronous):
  - pending pipe, FSM (RUN), wait_cnt, mem_timeout and stall_cnt clear immediately;
  - outputs forced to pc_en=0, IF_ID_en=0, pipe_en=0, flushes=0;
  - normal operation from the first edge after deassertion.
- A reset mid-freeze discards the wait state; a reset mid-stall discards pending loads.
- NUM_LOAD_STAGES=1 gives classic single-bubble load-use interlock.

Decomposition:
- Shared package hazard_pkg:
  - opcode constants (OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_OP, OP_STORE, OP_BRANCH);
  - NOP constant 32'h00000013;
  - typedef pend_t {logic valid; logic [4:0] rd}.
- One sub-module, inst_reg_use: combinational decode of a 32-bit instruction into rs1_used, rs2_used, is_load, rs1, rs2, rd. Instantiated twice (ID, EX).

Test Plan:
- NUM_LOAD_STAGES=1. EX=lw x5,0(x1); ID=add x6,x5,x7 → one cycle pc_en=0, IF_ID_en=0, ID_EX_flush=1; next cycle all enables 1; stall_cnt=1.
- NUM_LOAD_STAGES=2. lw x5 in EX then add x6,x5,x0 → two consecutive stall cycles (EX hit, then pending entry hit); stall_cnt=2.
- False-stall check: EX=lw x5; ID=lui x5,1 → no stall. ID=addi x7,x0,1 with lw x0 in EX → no stall.
- Same cycle, EX=load hazard with br_taken_EX_i=1 → IF_ID_flush=1, ID_EX_flush=1, pc_en=1, no stall.
- mem_ready_i=0 for 3 cycles with a load in EX and br_taken=1 → freeze (pipe_en=0, no flush). Pending pipe does not shift. Flush occurs on the cycle mem_ready_i rises.
- MEM_TIMEOUT=4. mem_ready_i low 6 cycles → mem_timeout rises on the 4th WAIT cycle and stays 1 after ready. rst_ni pulse mid-freeze → mem_timeout=0, stall_cnt=0, outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the RV32I pipeline interlock unit.
// Holds the 5-bit opcode constants (inst[6:2]), the canonical NOP and the
// pending-load entry type used by the load shadow pipe.
package hazard_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } pend_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/inst_reg_use.sv
// Combinational register-usage decode of one RV32I instruction.
// Ports:
//   inst_i      32-bit instruction
//   rs1_used_o  instruction reads rs1 (all but LUI/AUIPC/JAL)
//   rs2_used_o  instruction reads rs2 (OP, STORE, BRANCH only)
//   is_load_o   instruction is a load
//   rs1_o/rs2_o/rd_o  raw register fields
module inst_reg_use
  import hazard_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic        rs1_used_o,
  output logic        rs2_used_o,
  output logic        is_load_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o
);

  logic [4:0] opcode_s;
  logic       unused_bits_s;

  assign opcode_s      = inst_i[6:2];
  assign rs1_o         = inst_i[19:15];
  assign rs2_o         = inst_i[24:20];
  assign rd_o          = inst_i[11:7];
  assign is_load_o     = (opcode_s == OP_LOAD);
  // funct fields and the length bits play no part in hazard detection
  assign unused_bits_s = ^{inst_i[31:25], inst_i[14:12], inst_i[1:0]};

  // Source usage: only genuinely read registers may cause a stall
  always_comb begin
    rs1_used_o = 1'b1;
    rs2_used_o = 1'b0;
    case (opcode_s)
      OP_LUI, OP_AUIPC, OP_JAL: rs1_used_o = 1'b0;
      default:                  rs1_used_o = 1'b1;
    endcase
    case (opcode_s)
      OP_OP, OP_STORE, OP_BRANCH: rs2_used_o = 1'b1;
      default:                    rs2_used_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_unit_pipe.sv
// Pipeline interlock unit for the 5-stage RV32I core.
// Drives PC / pipeline-register enables and flushes from load-use hazards,
// data-memory readiness and taken branches; counts stall cycles.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   inst_ID_i, inst_EX_i     instructions in ID and EX
//   br_taken_EX_i            taken branch/jump resolved in EX
//   mem_ready_i              data memory can complete this cycle
//   pc_en, IF_ID_en          front-end enables
//   IF_ID_flush, ID_EX_flush bubble insertion
//   pipe_en                  back-end register enable
//   mem_timeout              sticky freeze-timeout flag
//   stall_cnt                saturating count of cycles with pc_en=0
module hazard_unit_pipe
  import hazard_pkg::*;
#(
  parameter int NUM_LOAD_STAGES = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int STALL_CNT_W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [31:0]            inst_ID_i,
  input  logic [31:0]            inst_EX_i,
  input  logic                   br_taken_EX_i,
  input  logic                   mem_ready_i,
  output logic                   pc_en,
  output logic                   IF_ID_en,
  output logic                   IF_ID_flush,
  output logic                   ID_EX_flush,
  output logic                   pipe_en,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int                PEND_D   = NUM_LOAD_STAGES - 1;
  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic       id_rs1_used_s, id_rs2_used_s, id_unused_load_s;
  logic [4:0] id_rs1_s, id_rs2_s, id_unused_rd_s;
  logic       ex_unused_rs1_used_s, ex_unused_rs2_used_s, ex_is_load_s;
  logic [4:0] ex_unused_rs1_s, ex_unused_rs2_s, ex_rd_s;

  inst_reg_use u_dec_id (
    .inst_i     (inst_ID_i),
    .rs1_used_o (id_rs1_used_s),
    .rs2_used_o (id_rs2_used_s),
    .is_load_o  (id_unused_load_s),
    .rs1_o      (id_rs1_s),
    .rs2_o      (id_rs2_s),
    .rd_o       (id_unused_rd_s)
  );

  inst_reg_use u_dec_ex (
    .inst_i     (inst_EX_i),
    .rs1_used_o (ex_unused_rs1_used_s),
    .rs2_used_o (ex_unused_rs2_used_s),
    .is_load_o  (ex_is_load_s),
    .rs1_o      (ex_unused_rs1_s),
    .rs2_o      (ex_unused_rs2_s),
    .rd_o       (ex_rd_s)
  );

  logic ex_load_valid_s, id_src1_s, id_src2_s;
  logic pend_hit_rs1_s, pend_hit_rs2_s, load_hz_s;

  // A load writing x0 never produces a hazard
  assign ex_load_valid_s = ex_is_load_s & (ex_rd_s != 5'd0);
  assign id_src1_s       = id_rs1_used_s & (id_rs1_s != 5'd0);
  assign id_src2_s       = id_rs2_used_s & (id_rs2_s != 5'd0);

  if (PEND_D > 0) begin : g_pend
    pend_t pend_q [PEND_D];
    pend_t pend_d [PEND_D];

    // Load results stay unforwardable while they travel the post-EX stages
    always_comb begin
      pend_d = pend_q;
      if (pipe_en) begin
        pend_d[0] = '{valid: ex_load_valid_s, rd: ex_rd_s};
        for (int j = 1; j < PEND_D; j++) begin
          pend_d[j] = pend_q[j-1];
        end
      end else begin
        pend_d = pend_q;
      end
    end

    // Pending-load register, cleared immediately by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int j = 0; j < PEND_D; j++) begin
          pend_q[j] <= '0;
        end
      end else begin
        pend_q <= pend_d;
      end
    end

    // Compare ID sources against every in-flight load
    always_comb begin
      pend_hit_rs1_s = 1'b0;
      pend_hit_rs2_s = 1'b0;
      for (int j = 0; j < PEND_D; j++) begin
        pend_hit_rs1_s = pend_hit_rs1_s | (pend_q[j].valid & (pend_q[j].rd == id_rs1_s));
        pend_hit_rs2_s = pend_hit_rs2_s | (pend_q[j].valid & (pend_q[j].rd == id_rs2_s));
      end
    end
  end else begin : g_no_pend
    assign pend_hit_rs1_s = 1'b0;
    assign pend_hit_rs2_s = 1'b0;
  end

  assign load_hz_s = (id_src1_s & ((ex_load_valid_s & (ex_rd_s == id_rs1_s)) | pend_hit_rs1_s)) |
                     (id_src2_s & ((ex_load_valid_s & (ex_rd_s == id_rs2_s)) | pend_hit_rs2_s));

  // Interlock priority: reset, memory freeze, branch flush, load stall, run
  always_comb begin
    pc_en       = 1'b0;
    IF_ID_en    = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    pipe_en     = 1'b0;
    if (!rst_ni) begin
      pc_en = 1'b0;
    end else if (!mem_ready_i) begin
      // Frozen EX keeps a taken branch alive; flush happens once ready
      pc_en = 1'b0;
    end else if (br_taken_EX_i) begin
      pc_en       = 1'b1;
      IF_ID_en    = 1'b1;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      pipe_en     = 1'b1;
    end else if (load_hz_s) begin
      pipe_en     = 1'b1;
      ID_EX_flush = 1'b1;
    end else begin
      pc_en    = 1'b1;
      IF_ID_en = 1'b1;
      pipe_en  = 1'b1;
    end
  end

  mem_state_e                   state_q, state_d;
  logic [WAIT_W-1:0]            wait_cnt_q, wait_cnt_d;
  logic                         timeout_q, timeout_d;
  logic [STALL_CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  // Freeze tracking; wait_cnt holds the number of consecutive not-ready cycles
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (!mem_ready_i) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (mem_ready_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
    timeout_d = timeout_q | (wait_cnt_d == WAIT_MAX);
    if (!pc_en && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, timeout and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
